// File: rtl/term_sched.sv
// Term scheduler: buffers one group of (lane, sign) terms, truncates to
// MAX_TERMS and replays each term for BIT_LEN cycles to the bit-serial adder.
module term_sched #(
    parameter int NUM_COE_ARRAY   = 16,
    parameter int INPUT_SEL_WIDTH = 4,
    parameter int MAX_TERMS       = 8,
    parameter int BIT_LEN         = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       term_valid,
    output logic                       term_ready,
    input  logic [INPUT_SEL_WIDTH-1:0] term_lane,
    input  logic                       term_sign,
    input  logic                       term_last,
    output logic [INPUT_SEL_WIDTH-1:0] input_selection,
    output logic                       sign_ctrl,
    output logic                       acc_en,
    output logic                       group_done,
    output logic                       trunc
);

    localparam int CW = $clog2(MAX_TERMS + 1);
    localparam int IW = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
    localparam int BW = (BIT_LEN > 1) ? $clog2(BIT_LEN) : 1;
    localparam logic [CW-1:0] N_MAX  = CW'(MAX_TERMS);
    localparam logic [BW-1:0] B_LAST = BW'(BIT_LEN - 1);

    if (INPUT_SEL_WIDTH < $clog2(NUM_COE_ARRAY)) begin : g_width_chk
        $error("INPUT_SEL_WIDTH too narrow for NUM_COE_ARRAY");
    end

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                     state, state_nx;
    logic [CW-1:0]              n, n_nx, k, k_nx, k_inc;
    logic [BW-1:0]              b, b_nx;
    logic [INPUT_SEL_WIDTH-1:0] lane_buf [MAX_TERMS];
    logic [MAX_TERMS-1:0]       sign_buf;
    logic                       wr_en;
    logic [IW-1:0]              wr_idx;
    logic                       accept;
    logic                       trunc_nx, sgn_nx, acc_nx, done_nx;
    logic [INPUT_SEL_WIDTH-1:0] sel_nx;

    assign term_ready = ((state == IDLE) || (state == LOAD)) && !reset;
    assign accept     = term_valid & term_ready;
    assign k_inc      = k + 1'b1;

    always_comb begin
        state_nx = state;
        n_nx     = n;
        k_nx     = k;
        b_nx     = b;
        wr_en    = 1'b0;
        wr_idx   = n[IW-1:0];
        trunc_nx = trunc;
        sel_nx   = input_selection;
        sgn_nx   = sign_ctrl;
        acc_nx   = 1'b0;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    wr_en    = 1'b1;
                    wr_idx   = '0;
                    n_nx     = CW'(1);
                    trunc_nx = 1'b0;
                    if (term_last) begin
                        // buffer[0] is written on this same edge
                        state_nx = RUN;
                        k_nx     = '0;
                        b_nx     = '0;
                        acc_nx   = 1'b1;
                        sel_nx   = term_lane;
                        sgn_nx   = term_sign;
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    if (n < N_MAX) begin
                        wr_en = 1'b1;
                        n_nx  = n + 1'b1;
                    end else begin
                        trunc_nx = 1'b1;
                    end
                    if (term_last) begin
                        state_nx = RUN;
                        k_nx     = '0;
                        b_nx     = '0;
                        acc_nx   = 1'b1;
                        sel_nx   = lane_buf[0];
                        sgn_nx   = sign_buf[0];
                    end
                end
            end
            RUN: begin
                acc_nx = 1'b1;
                if (b == B_LAST) begin
                    b_nx = '0;
                    if (k == n - 1'b1) begin
                        state_nx = DONE;
                        acc_nx   = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        k_nx   = k_inc;
                        sel_nx = lane_buf[k_inc[IW-1:0]];
                        sgn_nx = sign_buf[k_inc[IW-1:0]];
                    end
                end else begin
                    b_nx = b + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                n_nx     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            n               <= '0;
            k               <= '0;
            b               <= '0;
            lane_buf        <= '{default: '0};
            sign_buf        <= '0;
            input_selection <= '0;
            sign_ctrl       <= 1'b0;
            acc_en          <= 1'b0;
            group_done      <= 1'b0;
            trunc           <= 1'b0;
        end else begin
            state           <= state_nx;
            n               <= n_nx;
            k               <= k_nx;
            b               <= b_nx;
            input_selection <= sel_nx;
            sign_ctrl       <= sgn_nx;
            acc_en          <= acc_nx;
            group_done      <= done_nx;
            trunc           <= trunc_nx;
            if (wr_en) begin
                lane_buf[wr_idx] <= term_lane;
                sign_buf[wr_idx] <= term_sign;
            end
        end
    end

endmodule

// File: tb/tb_term_sched.sv
// Randomized bench for term_sched against a group-level reference model:
// kept terms = first min(cnt, MAX_TERMS), each replayed BIT_LEN cycles.
module tb_term_sched;

    localparam int NC = 16;
    localparam int SW = 4;
    localparam int MT = 8;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          term_valid;
    logic          term_ready;
    logic [SW-1:0] term_lane;
    logic          term_sign;
    logic          term_last;
    logic [SW-1:0] input_selection;
    logic          sign_ctrl;
    logic          acc_en;
    logic          group_done;
    logic          trunc;

    int n_pass = 0;
    int n_chk  = 0;

    logic [SW-1:0] q_lane[$];
    bit            q_sign[$];
    int            q_gap[$];
    bit            pend;
    logic [SW-1:0] pend_lane;
    bit            pend_sign;

    always #5 clk = ~clk;

    term_sched #(
        .NUM_COE_ARRAY  (NC),
        .INPUT_SEL_WIDTH(SW),
        .MAX_TERMS      (MT),
        .BIT_LEN        (BL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .term_valid     (term_valid),
        .term_ready     (term_ready),
        .term_lane      (term_lane),
        .term_sign      (term_sign),
        .term_last      (term_last),
        .input_selection(input_selection),
        .sign_ctrl      (sign_ctrl),
        .acc_en         (acc_en),
        .group_done     (group_done),
        .trunc          (trunc)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [SW-1:0] l, input bit s, input int g);
        q_lane.push_back(l);
        q_sign.push_back(s);
        q_gap.push_back(g);
    endtask

    task automatic clear_q();
        q_lane.delete();
        q_sign.delete();
        q_gap.delete();
    endtask

    task automatic gen_group(input int cnt);
        clear_q();
        for (int i = 0; i < cnt; i++) begin
            if (i == 0 && pend) begin
                push(pend_lane, pend_sign, 0);
            end else begin
                push(SW'($urandom_range(0, NC - 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
        end
        pend = 1'b0;
    endtask

    // Presents every queued beat; returns just after the term_last edge.
    task automatic load_beats();
        int cnt;
        cnt = q_lane.size();
        for (int i = 0; i < cnt; i++) begin
            for (int g = 0; g < q_gap[i]; g++) begin
                term_valid = 1'b0;
                tick();
                check("gap", {acc_en, group_done, term_ready}, 3'b001);
            end
            term_valid = 1'b1;
            term_lane  = q_lane[i];
            term_sign  = q_sign[i];
            term_last  = (i == cnt - 1);
            check("beat", {term_ready, acc_en}, 2'b10);
            tick();
        end
    endtask

    task automatic run_group(input bit hold);
        int cnt, kept;
        logic [SW+3:0] exp_v;
        cnt  = q_lane.size();
        kept = (cnt > MT) ? MT : cnt;
        load_beats();
        if (hold) begin
            term_valid = 1'b1;
            term_lane  = pend_lane;
            term_sign  = pend_sign;
            term_last  = 1'b0;
        end else begin
            term_valid = 1'b0;
            term_last  = 1'b0;
        end
        for (int c = 0; c < kept * BL; c++) begin
            exp_v = {1'b0, 1'b0, 1'b1, q_sign[c / BL], q_lane[c / BL]};
            check("run", {term_ready, group_done, acc_en, sign_ctrl,
                          input_selection}, exp_v);
            tick();
        end
        exp_v = {1'b0, 1'b1, 1'b0, (cnt > MT), q_lane[kept - 1]};
        check("done", {term_ready, group_done, acc_en, trunc,
                       input_selection}, exp_v);
        tick();
        check("idle", {term_ready, group_done, acc_en}, 3'b100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        term_valid = 1'b0;
        term_lane  = '0;
        term_sign  = 1'b0;
        term_last  = 1'b0;
        pend       = 1'b0;
        tick();
        tick();
        check("rst", {term_ready, acc_en, group_done, trunc, sign_ctrl,
                      input_selection}, 0);
        reset = 1'b0;
        #1;
        check("rst_rdy", term_ready, 1);

        clear_q();
        push(4'd2, 1'b0, 0);
        push(4'd5, 1'b1, 0);
        push(4'd15, 1'b0, 0);
        run_group(1'b0);

        clear_q();
        for (int i = 0; i < 10; i++) push(SW'(i), 1'($urandom_range(0, 1)), 0);
        run_group(1'b0);

        clear_q();
        push(4'd11, 1'b1, 0);
        push(4'd4, 1'b0, 3);
        run_group(1'b0);

        clear_q();
        push(4'd6, 1'b0, 0);
        push(4'd1, 1'b1, 0);
        pend      = 1'b1;
        pend_lane = 4'd13;
        pend_sign = 1'b1;
        run_group(1'b1);
        gen_group(3);
        run_group(1'b0);

        clear_q();
        push(4'd3, 1'b1, 0);
        push(4'd9, 1'b0, 0);
        load_beats();
        term_valid = 1'b0;
        term_last  = 1'b0;
        repeat (4) tick();
        check("run5", {acc_en, sign_ctrl, input_selection}, {1'b1, 1'b1, 4'd3});
        reset = 1'b1;
        #1;
        check("rst_mid_rdy", term_ready, 0);
        tick();
        check("rst_mid", {acc_en, group_done, sign_ctrl, trunc,
                          input_selection}, 0);
        reset = 1'b0;
        #1;
        check("rst_mid_rel", term_ready, 1);
        clear_q();
        push(4'd8, 1'b0, 0);
        run_group(1'b0);

        clear_q();
        push(4'd7, 1'b1, 0);
        run_group(1'b0);

        for (int g = 0; g < 40; g++) begin
            int  cnt;
            bit  hold;
            cnt  = $urandom_range(1, MT + 3);
            if (pend && cnt < 2) cnt = 2;
            gen_group(cnt);
            hold = ($urandom_range(0, 3) == 0);
            if (hold) begin
                pend      = 1'b1;
                pend_lane = SW'($urandom_range(0, NC - 1));
                pend_sign = 1'($urandom_range(0, 1));
            end
            run_group(hold);
            if (!hold && $urandom_range(0, 1) == 1) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
